instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the control unit.
- Holds the PC and requests instructions from instruction memory over a valid/ready request channel plus a response strobe.
- Presents the held instruction, with opcode and funct split out, to decode.
- Computes the next PC from the branch, zero and jump feedback on the cycle decode accepts the instruction.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/next_pc_calc.sv | 34 +++
 rtl/instr_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants used by fetch and the control
// unit, the fetch FSM state encoding, datapath widths and a helper that
// builds the word-scaled, sign-extended branch offset.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] J      = 6'h02;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2B;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    // Sign-extend a 16-bit immediate and scale it from words to bytes.
    function automatic logic [PC_W-1:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch unit.
// Priority: jump, then taken branch (branch && zero), then sequential.
// The result is always word aligned.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [PC_W-1:0]    pc_plus4,
    input  logic [INSTR_W-1:0] instr,
    input  logic               branch,
    input  logic               zero,
    input  logic               jump,
    output logic [PC_W-1:0]    next_pc
);

    logic [PC_W-1:0] target_s;
    logic            unused_opcode_s;

    // The opcode field takes no part in target selection.
    assign unused_opcode_s = ^instr[31:26];

    // Pick the redirect target by priority and force word alignment.
    always_comb begin
        target_s = pc_plus4;
        if (jump) begin
            target_s = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            target_s = pc_plus4 + branch_offset(instr[15:0]);
        end else begin
            target_s = pc_plus4;
        end
        next_pc = {target_s[PC_W-1:2], 2'b00};
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a valid/ready request
// channel with a one-cycle response strobe, presents the instruction to
// decode and advances the PC when decode accepts it. A fetch that sees no
// response within TIMEOUT_CYCLES parks the unit in HALT with a sticky error.
// Optional build macro IFETCH_PERF_EN adds retired/stall counters; without
// it both counter outputs are tied to zero.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic        fetch_err,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
);

    localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT_CYCLES);

    fetch_state_e         state_q;
    logic [PC_W-1:0]      pc_q;
    logic [PC_W-1:0]      pc_plus4_s;
    logic [PC_W-1:0]      pc_d;
    logic [INSTR_W-1:0]   instr_q;
    logic                 instr_valid_q;
    logic                 req_valid_q;
    logic                 fetch_err_q;
    logic [15:0]          tmo_q;
    logic [16:0]          tmo_inc_s;
    logic                 accept_s;

    assign pc_plus4_s = pc_q + 32'd4;
    assign tmo_inc_s  = {1'b0, tmo_q} + 17'd1;
    assign accept_s   = instr_valid_q && instr_ready;

    next_pc_calc u_next_pc_calc (
        .pc_plus4 (pc_plus4_s),
        .instr    (instr_q),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .next_pc  (pc_d)
    );

    // Fetch FSM: request handshake, response capture with timeout, issue to decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            req_valid_q   <= 1'b0;
            fetch_err_q   <= 1'b0;
            tmo_q         <= 16'd0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (req_valid_q && imem_req_ready) begin
                        req_valid_q <= 1'b0;
                        tmo_q       <= 16'd0;
                        state_q     <= ST_WAIT;
                    end else begin
                        req_valid_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        instr_q       <= imem_rsp_data;
                        instr_valid_q <= 1'b1;
                        tmo_q         <= 16'd0;
                        state_q       <= ST_ISSUE;
                    end else if (tmo_inc_s == TMO_LIMIT) begin
                        fetch_err_q <= 1'b1;
                        tmo_q       <= tmo_inc_s[15:0];
                        state_q     <= ST_HALT;
                    end else begin
                        tmo_q <= tmo_inc_s[15:0];
                    end
                end
                ST_ISSUE: begin
                    if (accept_s) begin
                        pc_q          <= pc_d;
                        instr_valid_q <= 1'b0;
                        req_valid_q   <= 1'b1;
                        state_q       <= ST_FETCH;
                    end else begin
                        instr_valid_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    req_valid_q   <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
                default: begin
                    req_valid_q   <= 1'b0;
                    instr_valid_q <= 1'b0;
                    state_q       <= ST_HALT;
                end
            endcase
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign opcode         = instr_q[31:26];
    assign funct          = instr_q[5:0];
    assign pc             = pc_q;
    assign pc_plus4       = pc_plus4_s;
    assign fetch_err      = fetch_err_q;

`ifdef IFETCH_PERF_EN
    logic [31:0] retired_q;
    logic [31:0] stall_q;

    // Count retired instructions and cycles spent waiting on memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 32'd0;
            stall_q   <= 32'd0;
        end else begin
            if (accept_s) begin
                retired_q <= retired_q + 32'd1;
            end
            if (state_q == ST_WAIT) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`else
    assign retired_cnt = 32'd0;
    assign stall_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit. The bench plays the
// instruction memory and the decode stage. A second instance with a high
// RESET_PC shares all inputs and is used to check jump targets that keep
// the upper PC nibble.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_ready = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic        jump = 1'b0;

    logic        imem_req_valid, instr_valid, fetch_err;
    logic [31:0] imem_addr, instr, pc, pc_plus4, retired_cnt, stall_cnt;
    logic [5:0]  opcode, funct;

    logic        j_req_valid, j_instr_valid, j_fetch_err;
    logic [31:0] j_addr, j_instr, j_pc, j_pc_plus4, j_retired, j_stall;
    logic [5:0]  j_opcode, j_funct;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .opcode(opcode),
        .funct(funct), .pc(pc), .pc_plus4(pc_plus4), .branch(branch),
        .zero(zero), .jump(jump), .fetch_err(fetch_err),
        .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
    );

    instr_fetch_unit #(.RESET_PC(32'h4000_0000), .TIMEOUT_CYCLES(8)) dut_j (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(j_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(j_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(j_instr_valid),
        .instr_ready(instr_ready), .instr(j_instr), .opcode(j_opcode),
        .funct(j_funct), .pc(j_pc), .pc_plus4(j_pc_plus4), .branch(branch),
        .zero(zero), .jump(jump), .fetch_err(j_fetch_err),
        .retired_cnt(j_retired), .stall_cnt(j_stall)
    );

    // Reset both instances; returns just after rst_n is released on a falling edge.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        instr_ready = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One complete fetch: accept request, respond next cycle, retire in ISSUE.
    task automatic do_fetch(input logic [31:0] data, input logic b, input logic z, input logic j,
                            output logic [31:0] addr_seen, output logic [31:0] instr_seen,
                            output logic [5:0] op_seen, output logic [5:0] fn_seen,
                            output logic [31:0] pc_seen, output logic [31:0] pc4_seen,
                            output int t_ret, output logic ok);
        int n;
        ok = 1'b1; n = 0; t_ret = 0;
        addr_seen = 32'h0; instr_seen = 32'h0; op_seen = 6'h0; fn_seen = 6'h0;
        pc_seen = 32'h0; pc4_seen = 32'h0;
        while (imem_req_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (imem_req_valid !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        addr_seen = imem_addr;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        if (instr_valid !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        instr_seen = instr; op_seen = opcode; fn_seen = funct;
        pc_seen = pc; pc4_seen = pc_plus4;
        branch = b; zero = z; jump = j; instr_ready = 1'b1;
        @(negedge clk);
        t_ret = cyc;
        instr_ready = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
    endtask

    logic [31:0] a, ins, p, p4;
    logic [5:0]  op, fn;
    int          t0, t1, t2;
    logic        ok;

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid got=%b exp=0", instr_valid); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_fetch_err got=%b exp=0", fetch_err); end
        checks++; if (pc !== 32'h0 || instr !== 32'h0) begin errors++; $display("FAIL rst_pc_instr got=%h/%h exp=0/0", pc, instr); end
        checks++; if (j_pc !== 32'h4000_0000) begin errors++; $display("FAIL rst_pc_j got=%h exp=40000000", j_pc); end
        checks++; if (retired_cnt !== 32'h0 || stall_cnt !== 32'h0) begin errors++; $display("FAIL rst_counters got=%h/%h exp=0/0", retired_cnt, stall_cnt); end
        rst_n = 1'b1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_release_early got=%b exp=0", imem_req_valid); end
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rst_first_req got=%b/%h exp=1/00000000", imem_req_valid, imem_addr); end
    endtask

    task automatic test_sequential();
        do_fetch(32'hAC22_0025, 1'b0, 1'b0, 1'b0, a, ins, op, fn, p, p4, t0, ok);
        checks++; if (ok !== 1'b1 || a !== 32'h0) begin errors++; $display("FAIL seq_addr0 got=%h ok=%b exp=00000000", a, ok); end
        checks++; if (ins !== 32'hAC22_0025 || op !== 6'h2B || fn !== 6'h25) begin errors++; $display("FAIL seq_fields got=%h/%h/%h exp=ac220025/2b/25", ins, op, fn); end
        checks++; if (p !== 32'h0 || p4 !== 32'h4) begin errors++; $display("FAIL seq_pc got=%h/%h exp=0/4", p, p4); end
        do_fetch(32'h2000_0000, 1'b0, 1'b0, 1'b0, a, ins, op, fn, p, p4, t1, ok);
        checks++; if (ok !== 1'b1 || a !== 32'h4) begin errors++; $display("FAIL seq_addr4 got=%h ok=%b exp=00000004", a, ok); end
        do_fetch(32'h2000_0000, 1'b0, 1'b0, 1'b0, a, ins, op, fn, p, p4, t2, ok);
        checks++; if (ok !== 1'b1 || a !== 32'h8) begin errors++; $display("FAIL seq_addr8 got=%h ok=%b exp=00000008", a, ok); end
        checks++; if (t1 - t0 !== 3 || t2 - t1 !== 3) begin errors++; $display("FAIL seq_spacing got=%0d/%0d exp=3/3", t1 - t0, t2 - t1); end
`ifdef IFETCH_PERF_EN
        checks++; if (retired_cnt !== 32'd3 || stall_cnt !== 32'd3) begin errors++; $display("FAIL seq_perf got=%0d/%0d exp=3/3", retired_cnt, stall_cnt); end
`else
        checks++; if (retired_cnt !== 32'd0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL seq_perf_off got=%0d/%0d exp=0/0", retired_cnt, stall_cnt); end
`endif
    endtask

    task automatic test_branch();
        do_fetch(32'h2000_0000, 1'b0, 1'b0, 1'b0, a, ins, op, fn, p, p4, t0, ok);
        checks++; if (ok !== 1'b1 || a !== 32'hC) begin errors++; $display("FAIL br_addrC got=%h exp=0000000c", a); end
        do_fetch(32'h1000_0003, 1'b1, 1'b1, 1'b0, a, ins, op, fn, p, p4, t0, ok);
        checks++; if (ok !== 1'b1 || a !== 32'h10) begin errors++; $display("FAIL br_addr10 got=%h exp=00000010", a); end
        checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL br_taken got=%h exp=00000020", imem_addr); end
        do_fetch(32'h0800_0004, 1'b0, 1'b0, 1'b1, a, ins, op, fn, p, p4, t0, ok);
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL br_jump_back got=%h exp=00000010", imem_addr); end
        do_fetch(32'h1000_0003, 1'b1, 1'b0, 1'b0, a, ins, op, fn, p, p4, t0, ok);
        checks++; if (ok !== 1'b1 || imem_addr !== 32'h14) begin errors++; $display("FAIL br_not_taken got=%h exp=00000014", imem_addr); end
    endtask

    task automatic test_jump();
        apply_reset();
        do_fetch(32'h0800_0040, 1'b0, 1'b0, 1'b1, a, ins, op, fn, p, p4, t0, ok);
        checks++; if (ok !== 1'b1 || j_addr !== 32'h4000_0100) begin errors++; $display("FAIL jmp_target got=%h exp=40000100", j_addr); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL jmp_target_low got=%h exp=00000100", imem_addr); end
        do_fetch(32'h0800_0080, 1'b1, 1'b1, 1'b1, a, ins, op, fn, p, p4, t0, ok);
        checks++; if (ok !== 1'b1 || j_addr !== 32'h4000_0200) begin errors++; $display("FAIL jmp_priority got=%h exp=40000200", j_addr); end
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL jmp_priority_low got=%h exp=00000200", imem_addr); end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_req_stable got=%0d unstable cycles exp=0", bad); end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_wait_req got=%b exp=0", imem_req_valid); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0123_4567;
        @(negedge clk);
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'hFFFF_FFFF;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (instr_valid !== 1'b1 || instr !== 32'h0123_4567 || imem_req_valid !== 1'b0 || pc !== 32'h200) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_issue_stable got=%0d unstable cycles exp=0", bad); end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h204) begin errors++; $display("FAIL bp_release got=%b/%b/%h exp=0/1/00000204", instr_valid, imem_req_valid, imem_addr); end
    endtask

    task automatic test_timeout();
        int bad;
        apply_reset();
        @(negedge clk);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        bad = 0;
        repeat (7) begin
            @(negedge clk);
            if (fetch_err !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL tmo_early got=%0d early cycles exp=0", bad); end
        @(negedge clk);
        checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL tmo_err got=%b exp=1", fetch_err); end
        repeat (3) @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b1) begin errors++; $display("FAIL tmo_halt got=%b/%b/%b exp=0/0/1", imem_req_valid, instr_valid, fetch_err); end
`ifdef IFETCH_PERF_EN
        checks++; if (stall_cnt !== 32'd8) begin errors++; $display("FAIL tmo_stall got=%0d exp=8", stall_cnt); end
`endif
        apply_reset();
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL tmo_clear got=%b exp=0", fetch_err); end
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL tmo_restart got=%b/%h exp=1/00000000", imem_req_valid, imem_addr); end
    endtask

    task automatic test_wrap_midreset();
        do_fetch(32'h1000_FFFE, 1'b1, 1'b1, 1'b0, a, ins, op, fn, p, p4, t0, ok);
        checks++; if (ok !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_branch_back got=%h exp=fffffffc", imem_addr); end
        do_fetch(32'h2000_0000, 1'b0, 1'b0, 1'b0, a, ins, op, fn, p, p4, t0, ok);
        checks++; if (p4 !== 32'h0 || imem_addr !== 32'h0 || fetch_err !== 1'b0) begin errors++; $display("FAIL wrap_zero got=%h/%h/%b exp=0/0/0", p4, imem_addr, fetch_err); end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL mid_rst_ignore got=%b/%h exp=0/00000000", instr_valid, instr); end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_rst_restart got=%b/%h exp=1/00000000", imem_req_valid, imem_addr); end
        checks++; if (retired_cnt !== 32'd0) begin errors++; $display("FAIL mid_rst_retired got=%0d exp=0", retired_cnt); end
        do_fetch(32'h2000_1234, 1'b0, 1'b0, 1'b0, a, ins, op, fn, p, p4, t0, ok);
        checks++; if (ok !== 1'b1 || ins !== 32'h2000_1234 || a !== 32'h0) begin errors++; $display("FAIL mid_rst_fetch got=%h@%h exp=20001234@00000000", ins, a); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_back_to_back();
        test_timeout();
        test_wrap_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
